// File: rtl/simon_pkg.sv
// simon_pkg: sizes, LED mode codes and control-FSM state encoding shared by the Simon blocks
package simon_pkg;
  localparam int PAT_W  = 4;
  localparam int ADDR_W = 6;
  typedef enum logic [2:0] {
    LED_OFF  = 3'b000,
    LED_IN   = 3'b001,
    LED_PLAY = 3'b010,
    LED_REP  = 3'b100,
    LED_DONE = 3'b111
  } led_mode_e;
  typedef enum logic [2:0] {
    S_INIT   = 3'd0,
    S_INPUT  = 3'd1,
    S_PLAY   = 3'd2,
    S_REPEAT = 3'd3,
    S_DONE   = 3'd4
  } state_e;
endpackage

// File: rtl/simon_regfile.sv
// simon_regfile: pattern store with one synchronous write port, one asynchronous read port and synchronous clear
module simon_regfile #(
  parameter int PAT_W  = 4,
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [PAT_W-1:0]  wdata_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [PAT_W-1:0]  rdata_o
);
  logic [PAT_W-1:0] mem_q [2**ADDR_W];
  // clear every entry on reset, otherwise store one pattern per write strobe
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < 2**ADDR_W; k++) mem_q[k] <= '0;
    end else if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end
  assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/simon_datapath.sv
// simon_datapath: sequence storage, index counters, legality check and LED mux for the Simon game
module simon_datapath
  import simon_pkg::*;
#(
  parameter int PAT_W  = simon_pkg::PAT_W,
  parameter int ADDR_W = simon_pkg::ADDR_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             level,
  input  logic [PAT_W-1:0] pattern,
  input  logic             reset,
  input  logic             count_ns,
  input  logic             rst_i,
  input  logic             count_i,
  input  logic             m1,
  input  logic             m2,
  input  logic             m3,
  input  logic             m4,
  output logic             legal,
  output logic             i_eq_ns,
  output logic             right_guess,
  output logic [PAT_W-1:0] pattern_leds
);
  localparam logic [ADDR_W-1:0] LAST = {ADDR_W{1'b1}};
  logic [ADDR_W-1:0] n_q, n_d, i_q, i_d;
  logic              lvl_q, lvl_d;
  logic [PAT_W-1:0]  rd_pat;
  logic              we;
  led_mode_e         mode;
  // game restart clears both counters and latches difficulty; counters saturate at the last entry
  always_comb begin
    n_d   = reset ? '0 : (count_ns && n_q != LAST) ? n_q + 1'b1 : n_q;
    i_d   = (reset || rst_i) ? '0 : (count_i && i_q != LAST) ? i_q + 1'b1 : i_q;
    lvl_d = reset ? level : lvl_q;
  end
  // counter and level registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      n_q   <= '0;
      i_q   <= '0;
      lvl_q <= 1'b0;
    end else begin
      n_q   <= n_d;
      i_q   <= i_d;
      lvl_q <= lvl_d;
    end
  end
  assign we = m1 && legal && !reset;
  simon_regfile #(.PAT_W(PAT_W), .ADDR_W(ADDR_W)) u_regfile (
    .clk     (clk),
    .rst_n   (rst_n),
    .we_i    (we),
    .waddr_i (n_q),
    .wdata_i (pattern),
    .raddr_i (i_q),
    .rdata_o (rd_pat)
  );
  // status flags and LED source, priority m1 > m2 > m3 > m4 if selects overlap
  always_comb begin
    legal        = lvl_q || $onehot(pattern);
    i_eq_ns      = i_q == n_q;
    right_guess  = pattern == rd_pat;
    mode         = m1 ? LED_IN : m2 ? LED_PLAY : m3 ? LED_REP : m4 ? LED_DONE : LED_OFF;
    pattern_leds = (mode == LED_IN || mode == LED_REP) ? pattern :
                   (mode == LED_PLAY || mode == LED_DONE) ? rd_pat : '0;
  end
endmodule

// File: tb/tb_simon_datapath.sv
// tb_simon_datapath: directed stimulus checked against a behavioural game model every cycle
module tb_simon_datapath;
  logic clk = 0, rst_n = 0, level = 0, reset = 0, count_ns = 0, rst_i = 0, count_i = 0;
  logic m1 = 0, m2 = 0, m3 = 0, m4 = 0;
  logic [3:0] pattern = 0;
  logic legal, i_eq_ns, right_guess;
  logic [3:0] pattern_leds;
  int checks = 0, errors = 0;
  bit started = 0;
  int mem_m [64];
  int n_m = 0, i_m = 0, lvl_m = 0;

  simon_datapath dut (
    .clk(clk), .rst_n(rst_n), .level(level), .pattern(pattern), .reset(reset),
    .count_ns(count_ns), .rst_i(rst_i), .count_i(count_i),
    .m1(m1), .m2(m2), .m3(m3), .m4(m4),
    .legal(legal), .i_eq_ns(i_eq_ns), .right_guess(right_guess), .pattern_leds(pattern_leds)
  );

  always #5 clk = ~clk;

  function automatic int ones(input int p);
    int c = 0;
    for (int b = 0; b < 4; b++) c += (p >> b) & 1;
    return c;
  endfunction

  function automatic int exp_legal();
    return (lvl_m != 0 || ones(int'(pattern)) == 1) ? 1 : 0;
  endfunction

  function automatic int exp_leds();
    if (m1) return int'(pattern);
    if (m2) return mem_m[i_m];
    if (m3) return int'(pattern);
    if (m4) return mem_m[i_m];
    return 0;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", name, act, exp);
    end
  endtask

  always @(posedge clk) begin
    if (!rst_n) begin
      n_m = 0; i_m = 0; lvl_m = 0;
      for (int k = 0; k < 64; k++) mem_m[k] = 0;
    end else if (reset) begin
      n_m = 0; i_m = 0; lvl_m = int'(level);
    end else begin
      if (m1 && exp_legal() == 1) mem_m[n_m] = int'(pattern);
      if (count_ns) n_m = (n_m + 1 > 63) ? 63 : n_m + 1;
      if (rst_i) i_m = 0;
      else if (count_i) i_m = (i_m + 1 > 63) ? 63 : i_m + 1;
    end
  end

  always @(negedge clk) begin
    if (started) begin
      chk("model_legal", int'(legal), exp_legal());
      chk("model_i_eq_ns", int'(i_eq_ns), (i_m == n_m) ? 1 : 0);
      chk("model_right_guess", int'(right_guess), (int'(pattern) == mem_m[i_m]) ? 1 : 0);
      chk("model_leds", int'(pattern_leds), exp_leds());
    end
  end

  task automatic step(input int cycles = 1);
    repeat (cycles) @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  initial begin
    step(2);
    started = 1;
    rst_n = 1; pattern = 4'b0000;
    settle();
    chk("rst_i_eq_ns", int'(i_eq_ns), 1);
    chk("rst_right_guess", int'(right_guess), 1);
    chk("rst_legal", int'(legal), 0);
    chk("rst_leds_nomode", int'(pattern_leds), 0);
    m4 = 1; settle();
    chk("rst_mem0_read", int'(pattern_leds), 0);
    m4 = 0;
    // legality at both levels
    reset = 1; level = 0; step(); reset = 0;
    pattern = 4'b0100; settle(); chk("legal_0100", int'(legal), 1);
    pattern = 4'b0110; settle(); chk("legal_0110", int'(legal), 0);
    pattern = 4'b0000; settle(); chk("legal_0000", int'(legal), 0);
    reset = 1; level = 1; step(); reset = 0; level = 0;
    pattern = 4'b0110; settle(); chk("legal_lvl1_0110", int'(legal), 1);
    // store two entries at level 0
    reset = 1; step(); reset = 0;
    m1 = 1; pattern = 4'b0001; settle(); chk("leds_m1", int'(pattern_leds), 1);
    step();
    m1 = 0; count_ns = 1; step();
    count_ns = 0; m1 = 1; pattern = 4'b0010; step();
    m1 = 0; m2 = 1; rst_i = 1; step();
    rst_i = 0; count_i = 1; settle();
    chk("play_led0", int'(pattern_leds), 1);
    chk("play_ieq0", int'(i_eq_ns), 0);
    step(); count_i = 0; settle();
    chk("play_led1", int'(pattern_leds), 2);
    chk("play_ieq1", int'(i_eq_ns), 1);
    // repeat check at i=1
    m2 = 0; m3 = 1;
    pattern = 4'b0010; settle(); chk("rep_right", int'(right_guess), 1);
    pattern = 4'b1000; settle(); chk("rep_wrong", int'(right_guess), 0);
    chk("rep_leds", int'(pattern_leds), 8);
    // strobe priority
    m3 = 0; count_i = 1; step(2);
    rst_i = 1; step(); rst_i = 0; count_i = 0;
    pattern = 4'b0001; settle();
    chk("rsti_wins_guess", int'(right_guess), 1);
    count_ns = 1; step(4); settle();
    chk("n5_ieq", int'(i_eq_ns), 0);
    reset = 1; step(); reset = 0; count_ns = 0; settle();
    chk("reset_wins_ieq", int'(i_eq_ns), 1);
    m4 = 1; settle(); chk("retained_mem0", int'(pattern_leds), 1);
    m4 = 0;
    // saturation of both counters
    count_ns = 1; step(70); count_ns = 0; settle();
    chk("sat_n_ieq", int'(i_eq_ns), 0);
    count_i = 1; step(63); settle();
    chk("sat_i63_ieq", int'(i_eq_ns), 1);
    step(7); count_i = 0; settle();
    chk("sat_hold_ieq", int'(i_eq_ns), 1);
    count_ns = 1; step(); count_ns = 0; settle();
    chk("sat_n_hold_ieq", int'(i_eq_ns), 1);
    step(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/simon_datapath.md
# simon_datapath

Datapath stage paired with the Simon control FSM: consumes its mode selects and counter strobes, stores the growing pattern sequence, and returns the status flags (`legal`, `i_eq_ns`, `right_guess`) that drive the FSM's transitions. It also selects the 4-bit pattern shown on the board LEDs for each mode. It sits between the board switches/LEDs and the control block, in the same clock domain.

## Interface
Parameters:
- `PAT_W`, 4, pattern width (one bit per switch/LED)
- `ADDR_W`, 6, sequence-index width; sequence holds up to 2^ADDR_W patterns

Ports:
- `clk`  in  1  system clock
- `rst_n`  in  1  reset, synchronous, active-low
- `level`  in  1  difficulty switch; sampled only on `reset`
- `pattern`  in  PAT_W  switch pattern from player
- `reset`  in  1  game restart strobe from control
- `count_ns`  in  1  increment stored-length counter `n`
- `rst_i`  in  1  clear index counter `i`
- `count_i`  in  1  increment `i`
- `m1`, `m2`, `m3`, `m4`  in  1 each  one-hot mode select: input / playback / repeat / done
- `legal`  out  1  current `pattern` is acceptable at latched level
- `i_eq_ns`  out  1  `i == n`
- `right_guess`  out  1  `pattern` equals stored entry at `i`
- `pattern_leds`  out  PAT_W  LED pattern for current mode

## Operation
- State: `n`, `i` (ADDR_W each), `lvl` (1), pattern memory (2^ADDR_W x PAT_W).
- `rst_n` low: `n`=0, `i`=0, `lvl`=0, all memory entries cleared to 0.
- `reset` high (and `rst_n` high): `n`=0, `i`=0, `lvl`<=`level`; memory untouched; overrides all other strobes that cycle.
- Write: `m1 & legal` writes `pattern` to memory[`n`] at the clock edge.
- `n`: `count_ns` increments; saturates at 2^ADDR_W-1 (no wrap, no further writes beyond last entry overwrite it).
- `i`: `rst_i` clears; else `count_i` increments, saturating at 2^ADDR_W-1. `rst_i` wins over `count_i` in the same cycle.
- `legal`: `lvl`=1 -> always 1; `lvl`=0 -> 1 iff exactly one bit of `pattern` set (0000 and multi-bit illegal).
- `i_eq_ns` = (`i` == `n`), combinational from registers.
- `right_guess` = (`pattern` == memory[`i`]), asynchronous read.
- `pattern_leds`: `m1` -> `pattern`; `m2` -> memory[`i`]; `m3` -> `pattern`; `m4` -> memory[`i`]; no mode asserted -> 0. Non-one-hot mode selects are illegal; priority m1>m2>m3>m4 applied.

## Timing
- All outputs combinational from registered state plus `pattern`/mode inputs; zero-cycle response to `pattern` changes.
- After `rst_n`: `n`=`i`=0, so `i_eq_ns`=1; `right_guess`=(`pattern`==0); `legal` per `lvl`=0; `pattern_leds` per mode.
- Register updates visible the cycle after the strobe edge; a write at `n` is readable at address `n` next cycle.
- Playback: one entry per clock (`count_i` every cycle); entries 0..`n` shown in order, `i_eq_ns` high on the last.
- Simultaneous `count_ns` and `count_i`: both apply independently; `i_eq_ns` next cycle uses both new values.
- `reset` mid-playback/repeat: `n`,`i` cleared next edge, prior memory contents retained but unreachable until rewritten.

## Structure
- Shared package `simon_pkg`: `PAT_W`, `ADDR_W` defaults, LED mode codes (001/010/100/111), state encoding shared with the control FSM.
- One sub-module: `simon_regfile` — 2^ADDR_W x PAT_W storage, one synchronous write port, one asynchronous read port, synchronous active-low clear.
- Counters, legality check and LED mux stay in the top.

## Test plan
- Reset: hold `rst_n`=0 two cycles, release with `pattern`=0000 -> `i_eq_ns`=1, `right_guess`=1, `legal`=0, memory reads 0.
- Legality: `reset` with `level`=0; `pattern`=0100 -> `legal`=1; 0110 -> 0; 0000 -> 0; then `reset` with `level`=1, 0110 -> `legal`=1.
- Store/replay: write 0001 (`m1`,`legal`), `count_ns`, write 0010; `m2` with `count_i` from `i`=0 -> `pattern_leds` 0001, 0010, `i_eq_ns`=1 on second.
- Repeat check: `m3`, `i`=1, memory[1]=0010; `pattern`=0010 -> `right_guess`=1; `pattern`=1000 -> 0.
- Strobe priority: `rst_i` and `count_i` together at `i`=3 -> `i`=0; `reset` with `count_ns` at `n`=5 -> `n`=0.
- Saturation: drive `count_ns` 70 times with ADDR_W=6 -> `n`=63, holds; `count_i` to 63 -> `i_eq_ns`=1, stays.
